pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register that replaces the fixed, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the rv32i core. It carries an opaque control bundle and data bundle from stage N to stage N+1 with a valid/ready handshake, synchronous flush, and bubble masking. An optional skid entry gives full throughput with a registered `in_ready`. One instance sits between each pair of pipeline stages; hazard and branch logic drive `out_ready` and `flush`.

---
 rtl/rv_pipe_pkg.sv | 26 ++
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared bundle widths and control-bit indices for rv32i stage registers
package rv_pipe_pkg;

    // IF/ID: pc, instr; control carries a single reserved bit
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;

    // ID/EX: RegWrite..Branch, ALUSrc, ALUOp[1:0]; pc, rs1, rs2, imm, rd, funct
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 137;

    // EX/MEM: alu_result, rs2_data, zero, branch_target, rd
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 102;

    // MEM/WB: RegWrite, MemToReg; mem_data, alu_result, rd
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 4;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic inter-stage register with flush, bubble masking and optional skid
module pipe_stage_reg
    import rv_pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              m_v;
    logic [CTRL_W-1:0] m_c;
    logic [DATA_W-1:0] m_d;
    logic              s_v;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_v & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [CTRL_W-1:0] s_c;
            logic [DATA_W-1:0] s_d;

            // in_ready depends only on the skid flop, breaking the out_ready path upstream
            assign in_ready = ~s_v & ~reset;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_v <= 1'b0;
                    m_c <= '0;
                    m_d <= '0;
                    s_v <= 1'b0;
                    s_c <= '0;
                    s_d <= '0;
                end else if (flush) begin
                    m_v <= 1'b0;
                    s_v <= 1'b0;
                end else if (!m_v) begin
                    if (in_fire) begin
                        m_v <= 1'b1;
                        m_c <= in_ctrl;
                        m_d <= in_data;
                    end
                end else if (out_fire) begin
                    if (s_v) begin
                        m_c <= s_c;
                        m_d <= s_d;
                        s_v <= 1'b0;
                    end else if (in_fire) begin
                        m_c <= in_ctrl;
                        m_d <= in_data;
                    end else begin
                        m_v <= 1'b0;
                    end
                end else if (in_fire) begin
                    s_v <= 1'b1;
                    s_c <= in_ctrl;
                    s_d <= in_data;
                end
            end
        end else begin : g_single
            assign s_v      = 1'b0;
            assign in_ready = (~m_v | out_ready) & ~reset;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_v <= 1'b0;
                    m_c <= '0;
                    m_d <= '0;
                end else if (flush) begin
                    m_v <= 1'b0;
                end else if (in_fire) begin
                    m_v <= 1'b1;
                    m_c <= in_ctrl;
                    m_d <= in_data;
                end else if (out_fire) begin
                    m_v <= 1'b0;
                end
            end
        end
    endgenerate

    // Bubbles must never carry write enables downstream; data is left stale
    assign out_valid = m_v;
    assign out_ctrl  = m_v ? m_c : '0;
    assign out_data  = m_d;
    assign occupancy = {1'b0, m_v} + {1'b0, s_v};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg (SKID=1 and SKID=0)
module tb_pipe_stage_reg;

    localparam int CW = 5;
    localparam int DW = 102;

    logic          clk = 1'b0;
    logic          reset;

    logic          fl, iv, ird, ov, ordy;
    logic [CW-1:0] ic, oc;
    logic [DW-1:0] id, od;
    logic [1:0]    occ;

    logic          fl0, iv0, ird0, ov0, ordy0;
    logic [CW-1:0] ic0, oc0;
    logic [DW-1:0] id0, od0;
    logic [1:0]    occ0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(fl),
        .in_valid(iv), .in_ready(ird), .in_ctrl(ic), .in_data(id),
        .out_valid(ov), .out_ready(ordy), .out_ctrl(oc), .out_data(od),
        .occupancy(occ)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(fl0),
        .in_valid(iv0), .in_ready(ird0), .in_ctrl(ic0), .in_data(id0),
        .out_valid(ov0), .out_ready(ordy0), .out_ctrl(oc0), .out_data(od0),
        .occupancy(occ0)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        fl = 1'b0; iv = 1'b0; ordy = 1'b1; ic = '0; id = '0;
        fl0 = 1'b0; iv0 = 1'b0; ordy0 = 1'b1; ic0 = '0; id0 = '0;
        #1;
        chk("rst_in_ready_held", ird, 0);
        chk("rst_out_valid", ov, 0);
        chk("rst_out_data", od, 0);
        chk("rst_occ", occ, 0);
        chk("rst0_in_ready_held", ird0, 0);

        @(posedge clk);
        tick();
        reset = 1'b0;
        #1;
        chk("rel_in_ready", ird, 1);
        chk("rel_out_valid", ov, 0);
        chk("rel_out_ctrl", oc, 0);
        chk("rel_occ", occ, 0);

        // streaming 1..8, one cycle latency, no gaps
        for (int i = 1; i <= 8; i++) begin
            iv = 1'b1; ic = 5'b10001; id = DW'(i);
            tick();
            chk("stream_valid", ov, 1);
            chk("stream_ctrl", oc, 5'b10001);
            chk("stream_data", od, i);
            chk("stream_occ", occ, 1);
        end

        // bubble with stale control on the input
        iv = 1'b0; ic = 5'b11111; id = 'h99;
        tick();
        chk("bubble_valid", ov, 0);
        chk("bubble_ctrl", oc, 0);
        chk("bubble_occ", occ, 0);

        // backpressure
        iv = 1'b1; ic = 5'b10001; id = 'h10;
        tick();
        chk("bp_first", od, 'h10);
        ordy = 1'b0; id = 'h11;
        tick();
        chk("bp_hold_data", od, 'h10);
        chk("bp_occ2", occ, 2);
        chk("bp_in_ready_low", ird, 0);
        id = 'h12;
        tick();
        chk("bp_still_data", od, 'h10);
        chk("bp_still_occ", occ, 2);
        ordy = 1'b1;
        tick();
        chk("bp_drain_11", od, 'h11);
        chk("bp_drain_occ", occ, 1);
        chk("bp_in_ready_up", ird, 1);
        tick();
        chk("bp_drain_12", od, 'h12);
        chk("bp_drain_valid", ov, 1);
        iv = 1'b0;
        tick();
        chk("bp_empty", ov, 0);

        // flush with both entries full
        iv = 1'b1; id = 'h20;
        tick();
        ordy = 1'b0; id = 'h21;
        tick();
        chk("fl_full_occ", occ, 2);
        id = 'h22; fl = 1'b1;
        tick();
        fl = 1'b0; iv = 1'b0; ordy = 1'b1;
        chk("fl_full_valid", ov, 0);
        chk("fl_full_ctrl", oc, 0);
        chk("fl_full_occ0", occ, 0);
        chk("fl_full_in_ready", ird, 1);
        tick();
        chk("fl_full_no_ghost", ov, 0);

        // flush with main full and a concurrent in_fire
        iv = 1'b1; id = 'h23;
        tick();
        ordy = 1'b0; id = 'h24; fl = 1'b1;
        #1;
        chk("fl_conc_in_ready", ird, 1);
        tick();
        fl = 1'b0; iv = 1'b0; ordy = 1'b1;
        chk("fl_conc_valid", ov, 0);
        chk("fl_conc_occ", occ, 0);
        tick();
        chk("fl_conc_no_ghost", ov, 0);

        // asynchronous reset mid-operation
        iv = 1'b1; id = 'h40;
        tick();
        chk("ar_loaded", ov, 1);
        iv = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", ov, 0);
        chk("ar_occ", occ, 0);
        chk("ar_data", od, 0);
        chk("ar_in_ready", ird, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("ar_rel_in_ready", ird, 1);

        // SKID=0: in_ready follows out_ready while occupied
        iv0 = 1'b1; ic0 = 5'b00101; id0 = 'h30; ordy0 = 1'b1;
        #1;
        chk("s0_empty_ready", ird0, 1);
        tick();
        chk("s0_d30", od0, 'h30);
        chk("s0_ctrl", oc0, 5'b00101);
        id0 = 'h31;
        #1;
        chk("s0_ready_follow1", ird0, 1);
        tick();
        chk("s0_d31", od0, 'h31);
        ordy0 = 1'b0; id0 = 'h32;
        #1;
        chk("s0_ready_follow0", ird0, 0);
        tick();
        chk("s0_hold31", od0, 'h31);
        chk("s0_occ", occ0, 1);
        ordy0 = 1'b1;
        #1;
        chk("s0_ready_follow1b", ird0, 1);
        tick();
        chk("s0_d32", od0, 'h32);
        iv0 = 1'b0; ic0 = 5'b11111;
        tick();
        chk("s0_empty_valid", ov0, 0);
        chk("s0_empty_ctrl", oc0, 0);
        ordy0 = 1'b0;
        #1;
        chk("s0_empty_ready_no_oready", ird0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
